// File: rtl/debounce_sync.sv
// Synchronizer plus debounce FSM: dout follows din only after STABLE_CNT stable cycles at s.
// Optional rise/fall pulse registers are compiled in with DEBOUNCE_SYNC_EDGE_EN.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_bad_sync_stages
    $error("debounce_sync: SYNC_STAGES must be 2..4");
  end
  if (STABLE_CNT < 2) begin : gen_bad_stable_cnt
    $error("debounce_sync: STABLE_CNT must be at least 2");
  end
  if (((64'(STABLE_CNT) - 64'd1) >> CNT_W) != 64'd0) begin : gen_bad_cnt_w
    $error("debounce_sync: CNT_W too narrow for STABLE_CNT-1");
  end

  typedef enum logic [1:0] {
    StIdleLow  = 2'b00,
    StWaitHigh = 2'b01,
    StIdleHigh = 2'b10,
    StWaitLow  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;

  // Pure flop chain; no logic between stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      StIdleLow: begin
        if (s) begin
          state_d = StWaitHigh;
          cnt_d   = '0;
        end
      end
      StWaitHigh: begin
        if (!s) begin
          state_d = StIdleLow;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdleHigh;
          cnt_d   = '0;
          dout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StIdleHigh: begin
        if (!s) begin
          state_d = StWaitLow;
          cnt_d   = '0;
        end
      end
      StWaitLow: begin
        if (s) begin
          state_d = StIdleHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdleLow;
          cnt_d   = '0;
          dout_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdleLow;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdleLow;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q == StWaitHigh) || (state_q == StWaitLow);

`ifdef DEBOUNCE_SYNC_EDGE_EN
  logic rise_q, fall_q;

  // dout only changes in one direction per edge, so the pulses are mutually exclusive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= ~dout_q & dout_d;
      fall_q <= dout_q & ~dout_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: vector table, directed corner cases and random
// stimulus against a sliding-window reference model.
module tb_debounce_sync;

  localparam int unsigned SS   = 2;
  localparam int unsigned SC   = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned HLEN = SS + SC + 1;
`ifdef DEBOUNCE_SYNC_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic dout, rise, fall, busy;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES(SS),
    .STABLE_CNT (SC),
    .CNT_W      (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: hist[i] is din sampled i edges ago; the FSM sees hist[SS] at each edge.
  // dout flips when the last SC+1 observed samples all disagree with it.
  logic [HLEN-1:0] hist;
  logic m_dout, m_rise, m_fall, m_busy;

  function automatic logic window_opposite(input logic [HLEN-1:0] h, input logic d);
    logic r;
    r = 1'b1;
    for (int i = SS; i <= SS + SC; i++) if (h[i] == d) r = 1'b0;
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist   <= '0;
      m_dout <= 1'b0;
      m_rise <= 1'b0;
      m_fall <= 1'b0;
      m_busy <= 1'b0;
    end else begin
      hist   <= {hist[HLEN-2:0], din};
      m_dout <= m_dout ^ window_opposite({hist[HLEN-2:0], din}, m_dout);
      m_rise <= EdgeEn & window_opposite({hist[HLEN-2:0], din}, m_dout) & ~m_dout;
      m_fall <= EdgeEn & window_opposite({hist[HLEN-2:0], din}, m_dout) & m_dout;
      m_busy <= hist[SS-1] != (m_dout ^ window_opposite({hist[HLEN-2:0], din}, m_dout));
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst === 1'b1) begin
      check("model_dout", dout, m_dout);
      check("model_rise", rise, m_rise);
      check("model_fall", fall, m_fall);
      check("model_busy", busy, m_busy);
      if (rise === 1'b1 && fall === 1'b1) check("rise_fall_excl", 1'b1, 1'b0);
    end
  end

  // Fields: din, dout, rise, fall, busy (expected after the edge that samples din).
  typedef struct packed {
    logic d;
    logic dout;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  localparam int NVEC = 28;
  localparam vec_t Vecs [NVEC] = '{
    5'b0_0_0_0_0, 5'b0_0_0_0_0, 5'b0_0_0_0_0, 5'b0_0_0_0_0,
    // clean rise
    5'b1_0_0_0_0, 5'b1_0_0_0_0, 5'b1_0_0_0_1, 5'b1_0_0_0_1,
    5'b1_0_0_0_1, 5'b1_0_0_0_1, 5'b1_1_1_0_0, 5'b1_1_0_0_0,
    // clean fall
    5'b0_1_0_0_0, 5'b0_1_0_0_0, 5'b0_1_0_0_1, 5'b0_1_0_0_1,
    5'b0_1_0_0_1, 5'b0_1_0_0_1, 5'b0_0_0_1_0, 5'b0_0_0_0_0,
    // three-cycle bounce high
    5'b1_0_0_0_0, 5'b1_0_0_0_0, 5'b1_0_0_0_1, 5'b0_0_0_0_1,
    5'b0_0_0_0_1, 5'b0_0_0_0_0, 5'b0_0_0_0_0, 5'b0_0_0_0_0
  };

  // Called at a negedge: drive din, advance one rising edge, return at the next negedge.
  task automatic step(input logic d);
    din = d;
    @(negedge clk);
  endtask

  task automatic edges_until(input logic target, input int limit, output int n, output int pulses);
    n      = 0;
    pulses = 0;
    do begin
      @(negedge clk);
      n++;
      if (rise === 1'b1 || fall === 1'b1) pulses++;
    end while (dout !== target && n < limit);
  endtask

  initial begin
    int n, pulses, falls;
    vec_t v;

    rst = 1'b0;
    din = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", dout, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_rise", rise, 1'b0);
    check("reset_fall", fall, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Idle low after release
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      check("idle_dout", dout, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_rise", rise, 1'b0);
      check("idle_fall", fall, 1'b0);
    end

    for (int i = 0; i < NVEC; i++) begin
      v = Vecs[i];
      step(v.d);
      check($sformatf("vec%0d_dout", i), dout, v.dout);
      check($sformatf("vec%0d_rise", i), rise, v.rise & EdgeEn);
      check($sformatf("vec%0d_fall", i), fall, v.fall & EdgeEn);
      check($sformatf("vec%0d_busy", i), busy, v.busy);
    end

    // Toggle every 2 cycles from dout=1, then settle low
    din = 1'b1;
    edges_until(1'b1, 20, n, pulses);
    check_int("toggle_setup_edges", n, 7);
    falls = 0;
    for (int i = 0; i < 20; i++) begin
      step(((i / 2) % 2) == 0 ? 1'b0 : 1'b1);
      check("toggle_hold_dout", dout, 1'b1);
      if (fall === 1'b1) falls++;
    end
    din = 1'b0;
    edges_until(1'b0, 20, n, pulses);
    check_int("toggle_fall_edges", n, 7);
    step(1'b0);
    if (fall === 1'b1) pulses++;
    check_int("toggle_fall_pulses", falls + pulses, EdgeEn ? 1 : 0);

    // Async reset from dout=1, then fresh qualification after release
    din = 1'b1;
    edges_until(1'b1, 20, n, pulses);
    check_int("pre_reset_edges", n, 7);
    #2 rst = 1'b0;
    #1;
    check("async_rst_dout", dout, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    edges_until(1'b1, 20, n, pulses);
    check_int("post_reset_edges", n, 7);
    check_int("post_reset_pulses", pulses, EdgeEn ? 1 : 0);

    // Reset while qualifying (cnt=2)
    din = 1'b0;
    edges_until(1'b0, 20, n, pulses);
    check_int("midwait_setup_edges", n, 7);
    repeat (5) step(1'b1);
    check("midwait_busy_before", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midwait_rst_busy", busy, 1'b0);
    check("midwait_rst_dout", dout, 1'b0);
    check("midwait_rst_rise", rise, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    edges_until(1'b1, 20, n, pulses);
    check_int("midwait_release_edges", n, 7);
    check_int("midwait_release_pulses", pulses, EdgeEn ? 1 : 0);

    // Random bursts with occasional short async reset pulses
    for (int i = 0; i < 300; i++) begin
      logic d;
      int   len;
      d   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 10));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 199) == 0) begin
          #2 rst = 1'b0;
          #2 rst = 1'b1;
        end
        din = d;
        @(negedge clk);
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end, got %0d failures so far", fails);
    $fatal(1);
  end

endmodule
